adder_operand_issue: RTL and testbench



---
 rtl/adder_pkg.sv | 21 ++
 rtl/opnd_fifo.sv | 53 +++++
 rtl/adder_operand_issue.sv | 88 ++++++++
 tb/tb_adder_operand_issue.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared widths, operand-triple type and carry helper for the adder issue stage
package adder_pkg;

    localparam int OPND_W        = 16;
    localparam int HALF_W        = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic              cin;
    } opnd_t;

    // Carry out of the low half, i.e. the carry the MSB half will consume.
    function automatic logic lo_carry(input opnd_t op);
        logic [HALF_W:0] s;
        s = {1'b0, op.a[HALF_W-1:0]} + {1'b0, op.b[HALF_W-1:0]} + {{HALF_W{1'b0}}, op.cin};
        return s[HALF_W];
    endfunction

endpackage

// File: rtl/opnd_fifo.sv
// rtl/opnd_fifo.sv - DEPTH-entry synchronous operand FIFO with full/empty flags
module opnd_fifo
    import adder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic  clk,
    input  logic  reset_b,
    input  logic  push,
    input  opnd_t wdata,
    input  logic  pop,
    output opnd_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    opnd_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/adder_operand_issue.sv
// rtl/adder_operand_issue.sv - operand issue stage with MSB-half clock-gate generation
module adder_operand_issue
    import adder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    input  logic              in_cin,
    input  logic              issue_en,
    output logic [OPND_W-1:0] a_out,
    output logic [OPND_W-1:0] b_out,
    output logic              cin_out,
    output logic              CG,
    output logic              res_valid,
    output logic [CNT_W-1:0]  gated_cnt
);

    opnd_t             in_op;
    opnd_t             head;
    logic              full;
    logic              empty;
    logic              issue;
    logic              issue_q;
    logic              cg_pos;
    logic              need_hi;
    logic [2*HALF_W:0] head_hi;
    logic [2*HALF_W:0] hi_state;

    assign in_op    = '{a: in_a, b: in_b, cin: in_cin};
    assign in_ready = ~full;
    assign issue    = issue_en & ~empty;

    opnd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_b (reset_b),
        .push    (in_valid),
        .wdata   (in_op),
        .pop     (issue),
        .rdata   (head),
        .full    (full),
        .empty   (empty)
    );

    // The MSB half only needs a clock when its inputs differ from the last issued ones.
    assign head_hi = {head.a[OPND_W-1:HALF_W], head.b[OPND_W-1:HALF_W], lo_carry(head)};
    assign need_hi = (head_hi != hi_state);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            a_out     <= '0;
            b_out     <= '0;
            cin_out   <= 1'b0;
            issue_q   <= 1'b0;
            cg_pos    <= 1'b0;
            hi_state  <= '0;
            res_valid <= 1'b0;
            gated_cnt <= '0;
        end else begin
            res_valid <= issue_q;
            if (issue_q && !CG && (gated_cnt != '1))
                gated_cnt <= gated_cnt + CNT_W'(1);
            if (issue) begin
                a_out    <= head.a;
                b_out    <= head.b;
                cin_out  <= head.cin;
                issue_q  <= 1'b1;
                cg_pos   <= need_hi;
                hi_state <= head_hi;
            end else begin
                issue_q  <= 1'b0;
                cg_pos   <= 1'b0;
            end
        end
    end

    // Retimed on the falling edge so clk & CG cannot glitch.
    always_ff @(negedge clk or negedge reset_b) begin
        if (!reset_b) CG <= 1'b0;
        else          CG <= cg_pos;
    end

endmodule

// File: tb/tb_adder_operand_issue.sv
// tb/tb_adder_operand_issue.sv - self-checking bench with queue model and gated adder stand-in
module tb_adder_operand_issue;
    import adder_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             clk = 1'b0;
    logic             reset_b = 1'b0;
    logic             in_valid = 1'b0;
    logic [15:0]      in_a = '0;
    logic [15:0]      in_b = '0;
    logic             in_cin = 1'b0;
    logic             issue_en = 1'b1;
    logic             in_ready;
    logic [15:0]      a_out;
    logic [15:0]      b_out;
    logic             cin_out;
    logic             CG;
    logic             res_valid;
    logic [CNT_W-1:0] gated_cnt;

    always #5 clk = ~clk;

    adder_operand_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .issue_en  (issue_en),
        .a_out     (a_out),
        .b_out     (b_out),
        .cin_out   (cin_out),
        .CG        (CG),
        .res_valid (res_valid),
        .gated_cnt (gated_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream adder: LSB half on clk, MSB half on the gated clock.
    logic [8:0]  lsb9;
    logic [7:0]  msb;
    logic [8:0]  lo_now;
    logic [15:0] sum_out;
    wire         gclk = clk & CG;
    assign lo_now  = {1'b0, a_out[7:0]} + {1'b0, b_out[7:0]} + {8'b0, cin_out};
    assign sum_out = {msb, lsb9[7:0]};

    always @(posedge clk or negedge reset_b)
        if (!reset_b) lsb9 <= '0;
        else          lsb9 <= lo_now;

    always @(posedge gclk or negedge reset_b)
        if (!reset_b) msb <= '0;
        else          msb <= a_out[15:8] + b_out[15:8] + {7'b0, lo_now[8]};

    // Behavioural model state.
    opnd_t            q[$];
    logic [15:0]      m_a, m_b, sum_pend, sum_resv;
    logic             m_cin, m_iq, m_cgpos, m_cg, m_resv;
    logic [16:0]      m_hi;
    logic [CNT_W-1:0] m_cnt;
    int               resv_cnt = 0;
    int               cg_rises = 0;

    function automatic void model_reset();
        q.delete();
        m_a = '0; m_b = '0; m_cin = 1'b0; m_iq = 1'b0; m_cgpos = 1'b0; m_cg = 1'b0;
        m_resv = 1'b0; m_hi = '0; m_cnt = '0; sum_pend = '0; sum_resv = '0;
    endfunction

    always begin : model_p
        int          sz;
        logic        acc, iss;
        opnd_t       h, nw;
        logic [8:0]  lo;
        logic [16:0] up;
        @(posedge clk or negedge reset_b);
        if (!reset_b) begin
            model_reset();
        end else begin
            sz  = q.size();
            acc = in_valid && (sz < DEPTH);
            iss = (sz > 0) && issue_en;
            if (m_iq && !m_cg && m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
            m_resv   = m_iq;
            sum_resv = sum_pend;
            if (iss) begin
                h        = q.pop_front();
                lo       = h.a[7:0] + h.b[7:0] + h.cin;
                up       = {h.a[15:8], h.b[15:8], lo[8]};
                m_cgpos  = (up != m_hi);
                m_hi     = up;
                m_a      = h.a;
                m_b      = h.b;
                m_cin    = h.cin;
                m_iq     = 1'b1;
                sum_pend = h.a + h.b + 16'(h.cin);
            end else begin
                m_iq    = 1'b0;
                m_cgpos = 1'b0;
            end
            if (acc) begin
                nw.a = in_a; nw.b = in_b; nw.cin = in_cin;
                q.push_back(nw);
            end
            #1;
            if (reset_b) begin
                chk("a_out", a_out, m_a);
                chk("b_out", b_out, m_b);
                chk("cin_out", cin_out, m_cin);
                chk("in_ready", in_ready, q.size() < DEPTH);
                chk("res_valid", res_valid, m_resv);
                chk("gated_cnt", gated_cnt, m_cnt);
                if (m_resv) chk("sum_out", sum_out, sum_resv);
                if (res_valid) resv_cnt++;
            end
        end
    end

    always begin : cg_model_p
        @(negedge clk);
        if (reset_b) m_cg = m_cgpos;
        #1;
        if (reset_b) chk("CG", CG, m_cg);
    end

    time t_rise = 0;
    always @(posedge gclk) t_rise = $time;
    always @(negedge gclk) if (reset_b) chk("gclk_width", 32'($time - t_rise), 32'd5);
    always @(CG) if (reset_b) chk("cg_edge_clk_low", clk, 1'b0);
    always @(posedge CG) cg_rises++;

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic r;
        int   n;
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1; n = 0;
        do begin
            r = in_ready;
            tick();
            n++;
        end while (!r && n < 100);
        if (!r) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    int rv0, cg0;

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_a_out", a_out, 16'h0);
        chk("rst_CG", CG, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_gated_cnt", gated_cnt, '0);
        tick();
        reset_b = 1'b1;

        rv0 = resv_cnt; cg0 = cg_rises;
        send(16'h0012, 16'h0034, 1'b0);
        repeat (3) tick();
        chk("t1_sum", sum_out, 16'h0046);
        chk("t1_gated", gated_cnt, 4'd1);
        chk("t1_resv", resv_cnt - rv0, 1);
        chk("t1_cg", cg_rises - cg0, 0);

        rv0 = resv_cnt; cg0 = cg_rises;
        send(16'h00FF, 16'h0001, 1'b0);
        repeat (3) tick();
        chk("t2_sum", sum_out, 16'h0100);
        chk("t2_gated", gated_cnt, 4'd1);
        chk("t2_cg", cg_rises - cg0, 1);

        rv0 = resv_cnt; cg0 = cg_rises;
        send(16'h1200, 16'h3400, 1'b0);
        send(16'h1200, 16'h3400, 1'b0);
        repeat (4) tick();
        chk("t3_sum", sum_out, 16'h4600);
        chk("t3_gated", gated_cnt, 4'd2);
        chk("t3_cg", cg_rises - cg0, 1);
        chk("t3_resv", resv_cnt - rv0, 2);

        issue_en = 1'b0;
        rv0 = resv_cnt; cg0 = cg_rises;
        for (int i = 0; i < 4; i++) send(16'h1200 + 16'(i), 16'h3400 + 16'(i), 1'b0);
        chk("t4_full", in_ready, 1'b0);
        in_a = 16'h1210; in_b = 16'h3410; in_cin = 1'b1; in_valid = 1'b1;
        repeat (3) tick();
        chk("t4_held", in_ready, 1'b0);
        chk("t4_no_resv", resv_cnt - rv0, 0);
        issue_en = 1'b1;
        send(16'h1210, 16'h3410, 1'b1);
        repeat (8) tick();
        chk("t4_resv", resv_cnt - rv0, 5);
        chk("t4_gated", gated_cnt, 4'd7);
        chk("t4_cg", cg_rises - cg0, 0);
        chk("t4_sum", sum_out, 16'h4621);

        issue_en = 1'b0;
        for (int i = 0; i < 3; i++) send(16'h5600 + 16'(i), 16'h0100, 1'b0);
        issue_en = 1'b1;
        tick();
        issue_en = 1'b0;
        reset_b  = 1'b0;
        #1;
        chk("t5_a_out", a_out, 16'h0);
        chk("t5_res_valid", res_valid, 1'b0);
        chk("t5_CG", CG, 1'b0);
        chk("t5_gated", gated_cnt, '0);
        chk("t5_in_ready", in_ready, 1'b1);
        tick();
        tick();
        reset_b  = 1'b1;
        issue_en = 1'b1;
        rv0 = resv_cnt;
        repeat (4) tick();
        chk("t5_no_reissue", resv_cnt - rv0, 0);
        chk("t5_a_hold", a_out, 16'h0);
        send(16'h0001, 16'h0002, 1'b0);
        repeat (4) tick();
        chk("t5_sum", sum_out, 16'h0003);
        chk("t5_gated1", gated_cnt, 4'd1);
        chk("t5_resv", resv_cnt - rv0, 1);

        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a     = {($urandom_range(0, 1) != 0) ? 8'h12 : 8'($urandom), 8'($urandom)};
            in_b     = {($urandom_range(0, 1) != 0) ? 8'h34 : 8'($urandom), 8'($urandom)};
            in_cin   = 1'($urandom);
            issue_en = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        issue_en = 1'b1;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule
